// File: rtl/axis_video_out.sv
// Video timing to AXI4-Stream bridge: framed pixel beats through a 2-entry skid buffer.
// Define AXIS_VIDEO_OUT_STATUS_EN to add the frame_done_cnt / frame_abort_cnt status ports.
module axis_video_out #(
  parameter int    DSIZE      = 24,
  parameter int    PPC        = 1,
  parameter string FRAME_SYNC = "OFF"
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [15:0]           hactive,
  input  logic [15:0]           vactive,
  input  logic                  in_vsync,
  input  logic [DSIZE*PPC-1:0]  in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DSIZE*PPC-1:0]  m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tuser,
  output logic                  m_tlast,
  output logic                  falign,
  output logic                  lalign,
  output logic                  ealign,
  output logic                  busy,
  output logic                  frame_abort
`ifdef AXIS_VIDEO_OUT_STATUS_EN
  ,
  output logic [15:0]           frame_done_cnt,
  output logic [15:0]           frame_abort_cnt
`endif
);

  localparam int          W     = DSIZE * PPC;
  localparam int          PSH   = (PPC == 4) ? 2 : (PPC == 2) ? 1 : 0;
  localparam logic [15:0] PPC16 = 16'(PPC);
  localparam bit          FS_ON = (FRAME_SYNC == "ON");

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t         state_reg;
  logic           vs_d1_reg, vs_d2_reg, vs_seen_reg, armed_reg, fsync_reg;
  logic [15:0]    bpl_reg, vact_reg, beat_cnt_reg, line_cnt_reg;
  logic           out_valid_reg, out_user_reg, out_last_reg;
  logic [W-1:0]   out_data_reg;
  logic           skid_valid_reg, skid_user_reg, skid_last_reg;
  logic [W-1:0]   skid_data_reg;
  logic           ealign_reg, abort_reg;

  logic geom_ok, accept, pop, beat_last, frame_last, first_beat, drained, finish, abort_now;

  assign geom_ok    = (hactive >= PPC16) && (vactive != 16'd0);
  assign in_ready   = (state_reg == ACTIVE) && !skid_valid_reg && !fsync_reg;
  assign accept     = in_valid && in_ready;
  assign pop        = out_valid_reg && m_tready;
  assign beat_last  = (beat_cnt_reg == bpl_reg - 16'd1);
  assign frame_last = beat_last && (line_cnt_reg == vact_reg - 16'd1);
  assign first_beat = (beat_cnt_reg == 16'd0) && (line_cnt_reg == 16'd0);
  assign drained    = !skid_valid_reg && (!out_valid_reg || pop);
  assign finish     = (state_reg == DRAIN) && drained;
  // A frame sync that coincides with the final drain completes the frame instead of aborting it
  assign abort_now  = fsync_reg && ((state_reg == ACTIVE) || ((state_reg == DRAIN) && !drained));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg      <= IDLE;
      vs_d1_reg      <= 1'b0;
      vs_d2_reg      <= 1'b0;
      vs_seen_reg    <= 1'b0;
      armed_reg      <= 1'b0;
      fsync_reg      <= 1'b0;
      bpl_reg        <= '0;
      vact_reg       <= '0;
      beat_cnt_reg   <= '0;
      line_cnt_reg   <= '0;
      out_valid_reg  <= 1'b0;
      out_user_reg   <= 1'b0;
      out_last_reg   <= 1'b0;
      out_data_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_user_reg  <= 1'b0;
      skid_last_reg  <= 1'b0;
      skid_data_reg  <= '0;
      ealign_reg     <= 1'b0;
      abort_reg      <= 1'b0;
    end else begin
      vs_d1_reg   <= in_vsync;
      vs_d2_reg   <= vs_d1_reg;
      vs_seen_reg <= 1'b1;
      // vsync held high through reset is not a fresh edge: wait to see it low first
      armed_reg   <= armed_reg | (vs_seen_reg & ~vs_d1_reg);
      fsync_reg   <= vs_d1_reg & ~vs_d2_reg & armed_reg;
      ealign_reg  <= finish;
      abort_reg   <= abort_now;

      if (!out_valid_reg || m_tready) begin
        if (skid_valid_reg) begin
          out_valid_reg  <= 1'b1;
          out_data_reg   <= skid_data_reg;
          out_user_reg   <= skid_user_reg;
          out_last_reg   <= skid_last_reg;
          skid_valid_reg <= 1'b0;
        end else begin
          out_valid_reg <= accept;
          if (accept) begin
            out_data_reg <= in_data;
            out_user_reg <= first_beat;
            out_last_reg <= beat_last;
          end
        end
      end else if (accept) begin
        skid_valid_reg <= 1'b1;
        skid_data_reg  <= in_data;
        skid_user_reg  <= first_beat;
        skid_last_reg  <= beat_last;
      end

      if (accept) begin
        if (beat_last) begin
          beat_cnt_reg <= 16'd0;
          line_cnt_reg <= line_cnt_reg + 16'd1;
        end else begin
          beat_cnt_reg <= beat_cnt_reg + 16'd1;
        end
      end

      if (abort_now) begin
        out_valid_reg  <= 1'b0;
        skid_valid_reg <= 1'b0;
      end

      if (fsync_reg) begin
        bpl_reg      <= 16'(hactive >> PSH);
        vact_reg     <= vactive;
        beat_cnt_reg <= 16'd0;
        line_cnt_reg <= 16'd0;
        state_reg    <= geom_ok ? ACTIVE : IDLE;
      end else begin
        case (state_reg)
          ACTIVE:  if (accept && frame_last) state_reg <= DRAIN;
          DRAIN:   if (finish) state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign m_tvalid    = out_valid_reg;
  assign m_tdata     = out_data_reg;
  assign m_tlast     = out_last_reg;
  assign m_tuser     = FS_ON ? fsync_reg : out_user_reg;
  assign falign      = fsync_reg;
  assign lalign      = pop && out_last_reg;
  assign ealign      = ealign_reg;
  assign busy        = (state_reg != IDLE);
  assign frame_abort = abort_reg;

`ifdef AXIS_VIDEO_OUT_STATUS_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_done_cnt  <= 16'd0;
      frame_abort_cnt <= 16'd0;
    end else begin
      if (finish)    frame_done_cnt  <= frame_done_cnt + 16'd1;
      if (abort_now) frame_abort_cnt <= frame_abort_cnt + 16'd1;
    end
  end
`else
  // Status counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_axis_video_out.sv
// Directed bench for axis_video_out: framing, stalls, invalid geometry, abort, reset, tuser-as-fsync.
module tb_axis_video_out;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [15:0] hactive, vactive;
  logic        in_valid, m_tready, vs1, vs2, vs3;
  logic [23:0] in_data1, in_data3;
  logic [47:0] in_data2;

  logic        in_ready1, m1_tvalid, m1_tuser, m1_tlast, falign1, lalign1, ealign1, busy1, abort1;
  logic [23:0] m1_tdata;
  logic        in_ready2, m2_tvalid, m2_tuser, m2_tlast, falign2, lalign2, ealign2, busy2, abort2;
  logic [47:0] m2_tdata;
  logic        in_ready3, m3_tvalid, m3_tuser, m3_tlast, falign3, lalign3, ealign3, busy3, abort3;
  logic [23:0] m3_tdata;
`ifdef AXIS_VIDEO_OUT_STATUS_EN
  logic [15:0] fdc1, fac1, fdc2, fac2, fdc3, fac3;
`endif

  axis_video_out #(.DSIZE(24), .PPC(1), .FRAME_SYNC("OFF")) dut1 (
    .aclk(aclk), .aresetn(aresetn), .hactive(hactive), .vactive(vactive), .in_vsync(vs1),
    .in_data(in_data1), .in_valid(in_valid), .in_ready(in_ready1), .m_tdata(m1_tdata),
    .m_tvalid(m1_tvalid), .m_tready(m_tready), .m_tuser(m1_tuser), .m_tlast(m1_tlast),
    .falign(falign1), .lalign(lalign1), .ealign(ealign1), .busy(busy1), .frame_abort(abort1)
`ifdef AXIS_VIDEO_OUT_STATUS_EN
    , .frame_done_cnt(fdc1), .frame_abort_cnt(fac1)
`endif
  );

  axis_video_out #(.DSIZE(24), .PPC(2), .FRAME_SYNC("OFF")) dut2 (
    .aclk(aclk), .aresetn(aresetn), .hactive(hactive), .vactive(vactive), .in_vsync(vs2),
    .in_data(in_data2), .in_valid(in_valid), .in_ready(in_ready2), .m_tdata(m2_tdata),
    .m_tvalid(m2_tvalid), .m_tready(m_tready), .m_tuser(m2_tuser), .m_tlast(m2_tlast),
    .falign(falign2), .lalign(lalign2), .ealign(ealign2), .busy(busy2), .frame_abort(abort2)
`ifdef AXIS_VIDEO_OUT_STATUS_EN
    , .frame_done_cnt(fdc2), .frame_abort_cnt(fac2)
`endif
  );

  axis_video_out #(.DSIZE(24), .PPC(1), .FRAME_SYNC("ON")) dut3 (
    .aclk(aclk), .aresetn(aresetn), .hactive(hactive), .vactive(vactive), .in_vsync(vs3),
    .in_data(in_data3), .in_valid(in_valid), .in_ready(in_ready3), .m_tdata(m3_tdata),
    .m_tvalid(m3_tvalid), .m_tready(m_tready), .m_tuser(m3_tuser), .m_tlast(m3_tlast),
    .falign(falign3), .lalign(lalign3), .ealign(ealign3), .busy(busy3), .frame_abort(abort3)
`ifdef AXIS_VIDEO_OUT_STATUS_EN
    , .frame_done_cnt(fdc3), .frame_abort_cnt(fac3)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitors: record every completed handshake and count status pulses
  logic [23:0] q1_data [64];
  logic        q1_user [64];
  logic        q1_last [64];
  logic [47:0] q2_data [64];
  logic        q2_user [64];
  logic        q2_last [64];
  int n1 = 0, n2 = 0, lal1 = 0, eal1 = 0, abt1 = 0, lal2 = 0, eal2 = 0;
  logic        p2_valid = 1'b0, p2_ready = 1'b0, p2_user = 1'b0, p2_last = 1'b0;
  logic [47:0] p2_data = '0;

  always @(negedge aclk) begin
    if (m1_tvalid && m_tready && n1 < 64) begin
      q1_data[n1] = m1_tdata; q1_user[n1] = m1_tuser; q1_last[n1] = m1_tlast; n1++;
    end
    if (m2_tvalid && m_tready && n2 < 64) begin
      q2_data[n2] = m2_tdata; q2_user[n2] = m2_tuser; q2_last[n2] = m2_tlast; n2++;
    end
    if (lalign1) lal1++;
    if (ealign1) eal1++;
    if (abort1)  abt1++;
    if (lalign2) lal2++;
    if (ealign2) eal2++;
    if (p2_valid && !p2_ready && m2_tvalid) begin
      check("stall_hold_data", m2_tdata, p2_data);
      check("stall_hold_last", m2_tlast, p2_last);
      check("stall_hold_user", m2_tuser, p2_user);
    end
    p2_valid = m2_tvalid; p2_ready = m_tready; p2_data = m2_tdata;
    p2_user = m2_tuser; p2_last = m2_tlast;
  end

  // Upstream source: data advances only on accepted beats
  int   d1 = 0, d2 = 0;
  logic a1, a2, tog = 1'b0;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      a1 = in_valid && in_ready1;
      a2 = in_valid && in_ready2;
      @(posedge aclk);
      #1;
      if (a1) d1++;
      if (a2) d2++;
      if (tog) m_tready = ~m_tready;
      in_data1 = 24'(d1);
      in_data2 = {24'(2 * d2 + 1), 24'(2 * d2)};
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int base, nb, na, l0, e0, ab0;

  initial begin
    hactive = 16'd4; vactive = 16'd2; in_valid = 1'b0; m_tready = 1'b1;
    vs1 = 1'b0; vs2 = 1'b0; vs3 = 1'b0;
    in_data1 = '0; in_data2 = '0; in_data3 = '0;
    tick(3);
    check("rst_tvalid", m1_tvalid, 1'b0);
    check("rst_in_ready", in_ready1, 1'b0);
    check("rst_busy", busy1, 1'b0);
    check("rst_tdata", m1_tdata, 24'h0);
    aresetn = 1'b1;
    tick(3);

    // 4x2 frame, PPC=1, free-flowing
    in_valid = 1'b1; base = d1;
    vs1 = 1'b1;
    tick(1); check("falign_early", falign1, 1'b0);
    tick(1); check("falign_edge2", falign1, 1'b1);
    check("busy_pre_start", busy1, 1'b0);
    tick(1); check("busy_active", busy1, 1'b1);
    check("falign_one_cycle", falign1, 1'b0);
    tick(12);
    check("f1_beats", n1, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("f1_data%0d", i), q1_data[i], 24'(base + i));
      check($sformatf("f1_user%0d", i), q1_user[i], (i == 0));
      check($sformatf("f1_last%0d", i), q1_last[i], (i == 3 || i == 7));
    end
    check("f1_lalign", lal1, 2);
    check("f1_ealign", eal1, 1);
    check("f1_busy_end", busy1, 1'b0);
    check("f1_no_abort", abt1, 0);
    vs1 = 1'b0;

    // PPC=2, 6x1 frame with m_tready toggling
    hactive = 16'd6; vactive = 16'd1; base = d2;
    vs2 = 1'b1;
    tick(3);
    tog = 1'b1; tick(20); tog = 1'b0; m_tready = 1'b1;
    tick(2);
    check("f2_beats", n2, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("f2_data%0d", i), q2_data[i], {24'(2 * (base + i) + 1), 24'(2 * (base + i))});
      check($sformatf("f2_user%0d", i), q2_user[i], (i == 0));
      check($sformatf("f2_last%0d", i), q2_last[i], (i == 2));
    end
    check("f2_lalign", lal2, 1);
    check("f2_ealign", eal2, 1);
    vs2 = 1'b0;

    // Invalid geometry: hactive=0 then vactive=0
    nb = n1; l0 = lal1; e0 = eal1; ab0 = abt1;
    hactive = 16'd0; vactive = 16'd2; vs1 = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(1); check("h0_busy", busy1, 1'b0); end
    vs1 = 1'b0; tick(2);
    hactive = 16'd4; vactive = 16'd0; vs1 = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(1); check("v0_busy", busy1, 1'b0); end
    vs1 = 1'b0; tick(2);
    check("bad_geom_beats", n1, nb);
    check("bad_geom_lalign", lal1, l0);
    check("bad_geom_ealign", eal1, e0);
    check("bad_geom_abort", abt1, ab0);

    // Abort after 3 of 8 beats, then a full restarted frame
    hactive = 16'd8; vactive = 16'd1; in_valid = 1'b1; m_tready = 1'b1; base = d1; nb = n1;
    vs1 = 1'b1; tick(1); vs1 = 1'b0; tick(2);
    for (int k = 0; k < 20 && (d1 - base) < 3; k++) tick(1);
    in_valid = 1'b0;
    check("abort_pre_accepted", d1 - base, 3);
    tick(2);
    check("abort_pre_emitted", n1 - nb, 3);
    vs1 = 1'b1; tick(1); vs1 = 1'b0; tick(1);
    check("abort_not_yet", abort1, 1'b0);
    tick(1);
    check("abort_pulse", abort1, 1'b1);
    check("abort_busy", busy1, 1'b1);
    na = n1; base = d1; in_valid = 1'b1;
    tick(1);
    check("abort_one_cycle", abort1, 1'b0);
    tick(13);
    check("restart_beats", n1 - na, 8);
    check("restart_user", q1_user[na], 1'b1);
    check("restart_data", q1_data[na], 24'(base));
    check("restart_last", q1_last[na + 7], 1'b1);
    check("abort_count", abt1 - ab0, 1);
`ifdef AXIS_VIDEO_OUT_STATUS_EN
    check("stat_abort_cnt", fac1, 16'd1);
    check("stat_done_cnt", fdc1, 16'd2);
`endif

    // FRAME_SYNC="ON": tuser is the fsync pulse
    in_valid = 1'b0; vs3 = 1'b1;
    tick(1); check("fs_on_tuser_early", m3_tuser, 1'b0);
    tick(1); check("fs_on_tuser_pulse", m3_tuser, 1'b1);
    check("fs_on_tvalid", m3_tvalid, 1'b0);
    tick(1); check("fs_on_tuser_end", m3_tuser, 1'b0);

    // Reset during a stall with a full skid buffer; vsync stays high afterwards
    tick(2);
    hactive = 16'd4; vactive = 16'd1; m_tready = 1'b0; in_valid = 1'b1;
    vs1 = 1'b1; tick(3); tick(3);
    check("stall_valid", m1_tvalid, 1'b1);
    check("skid_full", in_ready1, 1'b0);
    e0 = eal1; ab0 = abt1;
    #2 aresetn = 1'b0;
    #1;
    check("rst_mid_tvalid", m1_tvalid, 1'b0);
    check("rst_mid_tdata", m1_tdata, 24'h0);
    check("rst_mid_tlast", m1_tlast, 1'b0);
    check("rst_mid_busy", busy1, 1'b0);
    check("rst_mid_in_ready", in_ready1, 1'b0);
    tick(2);
    aresetn = 1'b1; m_tready = 1'b1; nb = n1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("post_rst_busy", busy1, 1'b0);
      check("post_rst_tvalid", m1_tvalid, 1'b0);
    end
    check("post_rst_beats", n1, nb);
    check("post_rst_ealign", eal1, e0);
    check("post_rst_abort", abt1, ab0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_video_out.md
AXIS_VIDEO_OUT -- requirements
Module: axis_video_out

Interface
REQ-001 SHALL have parameter DSIZE, default 24, bits per pixel.
REQ-002 SHALL have parameter PPC, default 1, pixels per beat (legal: 1, 2, 4).
REQ-003 SHALL have parameter FRAME_SYNC, default "OFF"; "ON" routes the fsync pulse onto tuser instead of the start-of-frame beat flag.
REQ-004 SHALL have port aclk, input, 1, clock; all logic is on its rising edge.
REQ-005 SHALL have port aresetn, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have ports hactive and vactive, input, 16 each, pixels per line and lines per frame; sampled at frame start.
REQ-007 SHALL have port in_vsync, input, 1, frame sync level; its rising edge starts a frame.
REQ-008 SHALL have port in_data, input, DSIZE*PPC, pixel data (pixel 0 in LSBs).
REQ-009 SHALL have ports in_valid (input, 1) and in_ready (output, 1), upstream valid/ready pop handshake.
REQ-010 SHALL have ports m_tdata (output, DSIZE*PPC), m_tvalid (output, 1), m_tready (input, 1), m_tuser (output, 1) and m_tlast (output, 1), AXI4-Stream master.
REQ-011 SHALL have ports falign, lalign and ealign, output, 1 each: one-cycle pulses for frame start, line end and frame end.
REQ-012 SHALL have ports busy (output, 1), high outside IDLE, and frame_abort (output, 1), a one-cycle pulse.

Function
REQ-013 SHALL detect the in_vsync rising edge with a 2-flop registered edge detector; the fsync pulse is 2 cycles after the edge; falign equals fsync.
REQ-014 SHALL implement FSM IDLE -> ACTIVE on fsync when hactive>=PPC and vactive>=1; otherwise stay in IDLE and produce no beats.
REQ-015 SHALL latch beats_per_line = hactive>>log2(PPC) (remainder pixels dropped) and vactive on the fsync cycle.
REQ-016 SHALL pass beats only in ACTIVE; in IDLE in_ready=0.
REQ-017 SHALL buffer through a 2-entry skid buffer with registered outputs: an input beat accepted in cycle N has m_tvalid=1 in cycle N+1 at the earliest.
REQ-018 SHALL drive in_ready=1 only when at least one skid entry is free and the FSM is in ACTIVE with beats of the frame outstanding; data SHALL never be lost or duplicated under any m_tready pattern.
REQ-019 SHALL hold m_tdata, m_tuser and m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-020 SHALL keep a beat counter (0..beats_per_line-1) and a line counter (0..vactive-1), both advanced on input acceptance; m_tlast SHALL be set on the beat where the beat counter equals beats_per_line-1.
REQ-021 SHALL set m_tuser on the first beat of a frame when FRAME_SYNC="OFF"; when "ON", SHALL set m_tuser=fsync with m_tvalid unaffected.
REQ-022 SHALL pulse lalign in the cycle an m_tlast beat completes a handshake on the output.
REQ-023 SHALL move ACTIVE -> DRAIN after the last input beat of the last line; DRAIN -> IDLE when the skid buffer is empty; ealign SHALL pulse on the DRAIN -> IDLE cycle.
REQ-024 SHALL handle fsync in ACTIVE or DRAIN by pulsing frame_abort, discarding skid contents, clearing counters, and restarting ACTIVE with the new geometry (abort and restart in the same cycle).
REQ-025 SHALL give an fsync in the same cycle as the final output handshake priority to ealign, then start the new frame.

Reset
REQ-026 SHALL make aresetn low asynchronously force IDLE, empty the skid buffer, clear counters and edge flops, and drive every output to 0.
REQ-027 SHALL require a fresh in_vsync rising edge after reset deassertion before any beat is emitted; reset mid-frame discards the frame without an ealign or frame_abort pulse.

Configuration
REQ-028 SHALL, when AXIS_VIDEO_OUT_STATUS_EN is defined, add output ports frame_done_cnt[15:0] (incremented per ealign) and frame_abort_cnt[15:0] (incremented per frame_abort), both wrapping at 16'hFFFF->0 and reset to 0.
REQ-029 SHALL, when AXIS_VIDEO_OUT_STATUS_EN is not defined, omit both ports and the counters; all other behaviour is identical.

Verification
REQ-030 SHALL cover: PPC=1, hactive=4, vactive=2, m_tready=1, in_valid=1 -> 8 beats, m_tuser on beat 0 only, m_tlast on beats 3 and 7, 2 lalign pulses, 1 ealign pulse.
REQ-031 SHALL cover: PPC=2, hactive=6, vactive=1, m_tready toggling 1/0 -> exactly 3 beats in order, data stable while stalled, m_tlast on beat 2.
REQ-032 SHALL cover: hactive=0 or vactive=0 with a vsync edge -> busy stays 0, no beats, no pulses.
REQ-033 SHALL cover: vsync edge after 3 of 8 beats -> frame_abort pulse, next accepted beat carries m_tuser, with STATUS_EN frame_abort_cnt=1.
REQ-034 SHALL cover: aresetn asserted during a stall with full skid -> all outputs 0 immediately; with no new vsync after release, no beats.
REQ-035 SHALL cover: FRAME_SYNC="ON" -> m_tuser pulses 2 cycles after the in_vsync rise, independent of beats.
